// File: rtl/cpu_control_unit.sv
// cpu_control_unit -- SM83 control unit. It tracks the M-cycle step of the current
// instruction and decodes the opcode held in the parent's IR into per-M-cycle control signals.
// Latency: outputs are combinational from (instruction_register, step). The step counter
// advances on the clk edge where t_cycle==3.
// Backpressure: none. The parent commits IR load and PC increment on that same edge.
// Optional feature: define ILLEGAL_LOCK_EN to make illegal opcodes lock the CPU until reset.
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   t_cycle[1:0]         - T-cycle within the M-cycle, owned by the parent
//   instruction_register - opcode currently executing
//   pc_next              - 0 = hold PC, 1 = PC+1 at end of M-cycle
//   inst_load            - parent loads mem_data_in into IR at t_cycle==3
//   mem_enable/mem_write - bus access enable / write strobe (always read today)
module cpu_control_unit #(
  parameter int STEP_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] t_cycle,
  input  logic [7:0] instruction_register,
  output logic       pc_next,
  output logic       inst_load,
  output logic       mem_enable,
  output logic       mem_write
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [STEP_W-1:0] last_step;  // index of the fetch M-cycle for this opcode
  logic              fetch;
  logic              locked;

  // Instruction length decode. Unlisted opcodes are single-cycle (fetch only).
  always_comb begin
    last_step = '0;
    case (instruction_register)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE:
        last_step = STEP_W'(1);
      8'h01, 8'h11, 8'h21, 8'h31:
        last_step = STEP_W'(2);
      default:
        last_step = '0;
    endcase
  end

`ifdef ILLEGAL_LOCK_EN
  // The lock takes effect once the illegal opcode sits in the IR, which is after its fetch.
  always_comb begin
    locked = 1'b0;
    case (instruction_register)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
        locked = 1'b1;
      default:
        locked = 1'b0;
    endcase
  end
`else
  assign locked = 1'b0;
`endif

  // Treat any step at or beyond the last one as the fetch cycle. This also covers
  // unreachable out-of-range steps.
  assign fetch = (step_q >= last_step);

  always_comb begin
    mem_write = 1'b0;  // reserved for future store instructions
    if (locked) begin
      mem_enable = 1'b0;
      inst_load  = 1'b0;
      pc_next    = 1'b0;
    end else begin
      // Operand reads and the fetch cycle both read the byte at PC and advance PC.
      mem_enable = 1'b1;
      inst_load  = fetch;
      pc_next    = 1'b1;
    end
  end

  always_comb begin
    step_d = step_q;
    if (locked) begin
      step_d = '0;
    end else if (t_cycle == 2'd3) begin
      step_d = fetch ? '0 : step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit -- directed bench for cpu_control_unit.
// It models the parent: the T-cycle counter, the IR and the PC.
module tb_cpu_control_unit;

  logic       clk;
  logic       reset;
  logic [1:0] t_cycle;
  logic [7:0] instruction_register;
  logic       pc_next;
  logic       inst_load;
  logic       mem_enable;
  logic       mem_write;

  int n_total = 0;
  int n_pass  = 0;
  int pc      = 0;

  cpu_control_unit #(.STEP_W(3)) dut (
    .clk                  (clk),
    .reset                (reset),
    .t_cycle              (t_cycle),
    .instruction_register (instruction_register),
    .pc_next              (pc_next),
    .inst_load            (inst_load),
    .mem_enable           (mem_enable),
    .mem_write            (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares outputs packed as {mem_enable, mem_write, inst_load, pc_next}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {mem_enable, mem_write, inst_load, pc_next};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: {en,wr,ld,inc} observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Runs one full M-cycle and checks the outputs at every T-cycle.
  // On the t_cycle==3 edge the parent commits IR load (from next_ir) and PC increment,
  // using the outputs the DUT actually presented.
  task automatic mcycle(input string tag, input logic [3:0] exp, input logic [7:0] next_ir);
    logic ld_s, inc_s;
    ld_s  = 1'b0;
    inc_s = 1'b0;
    for (int t = 0; t < 4; t++) begin
      t_cycle = 2'(t);
      @(negedge clk);
      chk_out($sformatf("%s_t%0d", tag, t), exp);
      ld_s  = inst_load;
      inc_s = pc_next;
      @(posedge clk);
      #1;
      if (t == 3) begin
        if (ld_s)  instruction_register = next_ir;
        if (inc_s) pc = pc + 1;
      end
    end
    t_cycle = 2'd0;
  endtask

  initial begin
    reset = 1'b1;
    t_cycle = 2'd0;
    instruction_register = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state: step is 0 and the outputs are the fetch values.
    @(negedge clk);
    chk_int("reset_step", int'(dut.step_q), 0);
    chk_out("reset_out", 4'b1011);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // NOP: every M-cycle is a fetch.
    mcycle("nop0", 4'b1011, 8'h00);
    mcycle("nop1", 4'b1011, 8'h00);
    mcycle("nop2", 4'b1011, 8'h00);
    chk_int("pc_after_3nop", pc, 3);
    mcycle("nop3", 4'b1011, 8'h3E);

    // 0x3E (LD A,d8): one operand read, then fetch.
    chk_int("ld_a_step0", int'(dut.step_q), 0);
    mcycle("ld_a_m0", 4'b1001, 8'h00);
    chk_int("ld_a_step1", int'(dut.step_q), 1);
    mcycle("ld_a_m1", 4'b1011, 8'h21);
    chk_int("pc_after_3e", pc, 6);

    // 0x21 (LD HL,d16): step sequence 0,1,2,0.
    chk_int("ld_hl_step0", int'(dut.step_q), 0);
    mcycle("ld_hl_m0", 4'b1001, 8'h00);
    chk_int("ld_hl_step1", int'(dut.step_q), 1);
    mcycle("ld_hl_m1", 4'b1001, 8'h00);
    chk_int("ld_hl_step2", int'(dut.step_q), 2);
    mcycle("ld_hl_m2", 4'b1011, 8'hC6);
    chk_int("ld_hl_step_wrap", int'(dut.step_q), 0);
    chk_int("pc_after_21", pc, 9);

    // 0xC6 (ADD A,d8)
    mcycle("add_m0", 4'b1001, 8'h00);
    mcycle("add_m1", 4'b1011, 8'h31);
    chk_int("pc_after_c6", pc, 11);

    // 0x31 (LD SP,d16)
    mcycle("ld_sp_m0", 4'b1001, 8'h00);
    mcycle("ld_sp_m1", 4'b1001, 8'h00);
    mcycle("ld_sp_m2", 4'b1011, 8'h01);
    chk_int("pc_after_31", pc, 14);

    // 0x01: assert reset at t_cycle==1 during step 1.
    mcycle("ld_bc_m0", 4'b1001, 8'h00);
    chk_int("ld_bc_step1", int'(dut.step_q), 1);
    t_cycle = 2'd0;
    @(posedge clk);
    #1;
    t_cycle = 2'd1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t_cycle = 2'd0;
    chk_int("midreset_step", int'(dut.step_q), 0);
    @(negedge clk);
    chk_out("midreset_out", 4'b1001);  // IR still 0x01, step 0: operand read
    @(posedge clk);
    #1;
    pc = 0;
    mcycle("ld_bc_r_m0", 4'b1001, 8'h00);
    mcycle("ld_bc_r_m1", 4'b1001, 8'h00);
    mcycle("ld_bc_r_m2", 4'b1011, 8'hD3);
    chk_int("pc_after_01", pc, 3);

`ifdef ILLEGAL_LOCK_EN
    // 0xD3 locks the CPU: no bus access, no PC or IR change, and step pinned at 0.
    for (int m = 0; m < 12; m++) begin
      mcycle($sformatf("lock_m%0d", m), 4'b0000, 8'h00);
    end
    chk_int("lock_pc_held", pc, 3);
    chk_int("lock_step", int'(dut.step_q), 0);
    reset = 1'b1;
    instruction_register = 8'h00;  // the parent's IR resets together with the CPU
    @(posedge clk);
    #1;
    reset = 1'b0;
    mcycle("recover_nop", 4'b1011, 8'hCB);
`else
    // Without the lock feature, 0xD3 executes as a 1-M-cycle NOP.
    mcycle("d3_nop", 4'b1011, 8'hCB);
    chk_int("pc_after_d3", pc, 4);
`endif

    // An opcode with no decode entry executes as a NOP.
    mcycle("cb_nop", 4'b1011, 8'h00);
    chk_int("step_after_cb", int'(dut.step_q), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Control unit of the SM83 (Game Boy) CPU core.
- Tracks the M-cycle step within the current instruction and decodes the opcode held by the parent's instruction register. Produces per-M-cycle control: PC update, instruction-register load, bus enable/write.
- The parent CPU owns the T-cycle counter, instruction register and PC. It commits IR load and PC increment on the clk edge where t_cycle==3, using this block's outputs.

Parameters:
- STEP_W, 3, width of the internal M-cycle step counter; must be >=2.

Ports:
- clk  input  1  system clock (4 MHz nominal)
- reset  input  1  synchronous, active-high reset
- t_cycle  input  2  current T-cycle within the M-cycle (0..3, wraps), driven by parent
- instruction_register  input  8  opcode of the instruction currently executing
- pc_next  output  1  0=PcNextSame (hold PC), 1=PcNextInc (PC+1 at end of M-cycle)
- inst_load  output  1  parent loads mem_data_in into IR at t_cycle==3
- mem_enable  output  1  system bus access enable for this M-cycle
- mem_write  output  1  system bus write enable (0 = read)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- State: step register (STEP_W bits). On posedge clk:
  - reset=1: step<=0.
  - Else, if t_cycle==3: step<=0 on the last M-cycle of the instruction, otherwise step+1.
  - Other T-cycles: hold.
- Outputs are purely combinational from (instruction_register, step). They are constant across all four T-cycles of an M-cycle; t_cycle is used only for step advance.
- Last M-cycle of every instruction is the fetch cycle: mem_enable=1, mem_write=0, inst_load=1, pc_next=Inc. The new opcode and step=0 take effect on the same edge.
- Operand-read M-cycle (reads byte at PC): mem_enable=1, mem_write=0, inst_load=0, pc_next=Inc.
- Decode (length in M-cycles):
  - 0x00 NOP: 1 (fetch only).
  - 8-bit immediate 0x06,0x0E,0x16,0x1E,0x26,0x2E,0x3E, 0xC6,0xCE,0xD6,0xDE,0xE6,0xEE,0xF6,0xFE: 2 (operand read, fetch).
  - 16-bit immediate loads 0x01,0x11,0x21,0x31: 3 (operand read x2, fetch).
  - All other opcodes: 1 (treated as NOP), except illegal opcodes when ILLEGAL_LOCK_EN is defined.
- mem_write is 0 for every decoded M-cycle; it is reserved for future store instructions.
- Reset values: step=0. With the parent's IR reset to 0x00, outputs are fetch values (mem_enable=1, inst_load=1, pc_next=Inc, mem_write=0).
- Reset mid-instruction: step returns to 0 on that edge regardless of t_cycle. The partially executed instruction is abandoned.
- step never exceeds 2 for decoded instructions. An out-of-range step (unreachable) behaves as the fetch cycle.

Optional Feature:
- Macro ILLEGAL_LOCK_EN.
- Defined: opcodes 0xD3,0xDB,0xDD,0xE3,0xE4,0xEB,0xEC,0xED,0xF4,0xFC,0xFD lock the CPU.
  - mem_enable=0, mem_write=0, inst_load=0, pc_next=Same, and step holds at 0, until reset.
- Undefined: these opcodes execute as 1-M-cycle NOPs.

Test Plan:
- Reset with IR=0x00, run 12 clocks -> inst_load and pc_next=Inc high every M-cycle. Parent PC reads 3 after 3 full M-cycles; mem_enable constant 1.
- IR=0x3E loaded -> M0: inst_load=0, pc_next=Inc, mem_enable=1. M1: inst_load=1, pc_next=Inc. PC advances 2 over the instruction.
- IR=0x21 -> inst_load low for two M-cycles, high on the third. PC advances 3; step sequence 0,1,2,0.
- Assert reset at t_cycle==1 during step 1 of 0x01 -> step=0 next cycle; outputs reflect IR then present at step 0.
- IR=0xD3 with ILLEGAL_LOCK_EN -> after fetch, mem_enable=0, inst_load=0, pc_next=Same held for 40+ clocks. Reset recovers. Without the macro, 0xD3 behaves as NOP.
- Verify outputs stable across t_cycle 0..3 for every M-cycle of 0x00, 0xC6 and 0x31; mem_write is never 1.
